// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte requesters, MAX_BURST bytes per turn.
// req_ready is a same-cycle accept with the grant; tx_start follows one cycle later; frames are paced by tx_busy.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int MAX_BURST    = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     arb_busy,
  output logic                     err_timeout
);

  localparam int IDW = $clog2(N_REQ);
  localparam int BW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int TW  = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  // tx_start cycle itself counts toward the timeout window, so the counter stops two short.
  localparam logic [TW-1:0] TMO_LAST   = TW'(BUSY_TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t         state_q;
  logic [IDW-1:0] last_grant_q;
  logic [IDW-1:0] grant_id_q;
  logic [BW-1:0]  burst_cnt_q;
  logic [TW-1:0]  tmo_cnt_q;
  logic [7:0]     tx_data_q;
  logic           tx_start_q;
  logic           arb_busy_q;
  logic           err_q;

  logic           rr_vld_d;
  logic [IDW-1:0] rr_idx_d;
  logic [IDW-1:0] rr_cand;
  logic           grant;
  logic           timed_out;
  logic           frame_end;
  logic           burst_cont;

  // Walk from the farthest candidate to the nearest so the closest to last_grant+1 wins.
  always_comb begin
    rr_vld_d = 1'b0;
    rr_idx_d = '0;
    rr_cand  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      rr_cand = last_grant_q + IDW'(k);
      if (req_valid[rr_cand]) begin
        rr_vld_d = 1'b1;
        rr_idx_d = rr_cand;
      end
    end
  end

  assign grant      = (state_q == IDLE) && !tx_busy && rr_vld_d;
  assign timed_out  = (state_q == WAIT_BUSY) && !tx_busy && (tmo_cnt_q == TMO_LAST);
  assign frame_end  = ((state_q == WAIT_DONE) && !tx_busy) || timed_out;
  assign burst_cont = frame_end && req_valid[grant_id_q] && (burst_cnt_q < BURST_LAST);

  // Gated by rst so nothing is accepted while reset is held, even though IDLE decodes a grant.
  always_comb begin
    req_ready = '0;
    if (rst) begin
      if (grant) begin
        req_ready[rr_idx_d] = 1'b1;
      end else if (burst_cont) begin
        req_ready[grant_id_q] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(N_REQ - 1);
      grant_id_q   <= '0;
      burst_cnt_q  <= '0;
      tmo_cnt_q    <= '0;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      arb_busy_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            state_q     <= ISSUE;
            tx_start_q  <= 1'b1;
            arb_busy_q  <= 1'b1;
            grant_id_q  <= rr_idx_d;
            tx_data_q   <= req_data[8*rr_idx_d +: 8];
            burst_cnt_q <= '0;
          end
        end
        ISSUE: begin
          tmo_cnt_q <= '0;
          state_q   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (!timed_out) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        WAIT_DONE: begin
        end
        default: state_q <= IDLE;
      endcase

      if (timed_out) begin
        err_q <= 1'b1;
      end

      // A timed-out byte leaves exactly like a completed frame.
      if (frame_end) begin
        if (burst_cont) begin
          state_q     <= ISSUE;
          tx_start_q  <= 1'b1;
          tx_data_q   <= req_data[8*grant_id_q +: 8];
          burst_cnt_q <= burst_cnt_q + 1'b1;
        end else begin
          state_q      <= IDLE;
          arb_busy_q   <= 1'b0;
          last_grant_q <= grant_id_q;
        end
      end
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign arb_busy    = arb_busy_q;
  assign err_timeout = err_q;

endmodule
